mult_div_ctrl: RTL and testbench

- Sequential HI/LO multiply/divide unit with its own controller.
- Sits beside the ALU in the execute stage and decodes the R-type funct codes that ALU_Ctrl does not handle: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Runs one iterative shift-add or restoring-divide step per cycle.
- Owns the HI/LO registers and raises a stall to the PC/pipeline when an instruction needs HI/LO while an operation is still in flight.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/md_step.sv | 36 +++
 rtl/mult_div_ctrl.sv | 143 ++++++++++++++
 tb/tb_mult_div_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and multiply/divide controller types.
package mips_pkg;

  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} md_state_e;
  typedef enum logic {MdMul, MdDiv} md_mode_e;

  // Quotient reported for a zero divisor; sliced to DATA_W by users.
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/md_step.sv
// One iteration of shift-add multiply or restoring divide on a {rem, quot} pair.
module md_step
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  md_mode_e          mode_i,
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] opnd_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_shift;
  logic            w_ge;

  always_comb begin
    w_sum   = {1'b0, rem_i} + {1'b0, opnd_i};
    w_shift = {rem_i, quot_i[DATA_W-1]};
    w_ge    = w_shift >= {1'b0, opnd_i};
    rem_o   = rem_i;
    quot_o  = quot_i;
    if (mode_i == MdDiv) begin
      // Difference is below the divisor, so it always fits in DATA_W bits.
      rem_o  = w_ge ? (w_shift[DATA_W-1:0] - opnd_i) : w_shift[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], w_ge};
    end else if (quot_i[0]) begin
      {rem_o, quot_o} = {w_sum, quot_i[DATA_W-1:1]};
    end else begin
      {rem_o, quot_o} = {1'b0, rem_i, quot_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Iterative HI/LO multiply/divide unit: decodes md functs, sequences steps,
// applies sign fixup and stalls the pipeline while an operation is in flight.
module mult_div_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              md_en_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] mf_data_o
);

  localparam int unsigned       CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  md_state_e         r_state;
  logic [CNT_W-1:0]  r_count;
  logic              r_busy, r_is_div, r_neg_res, r_neg_rem, r_div0;
  logic [DATA_W-1:0] r_hi, r_lo, r_acc_hi, r_acc_lo, r_opnd;

  logic w_mfhi, w_mflo, w_mthi, w_mtlo, w_start_mul, w_start_div, w_signed, w_md_op;
  logic w_rs_neg, w_rt_neg;
  logic [DATA_W-1:0]   w_rs_mag, w_rt_mag, w_nxt_hi, w_nxt_lo, w_quot, w_rem;
  logic [2*DATA_W-1:0] w_prod;
  md_mode_e            w_mode;

  always_comb begin
    w_mfhi      = 1'b0;
    w_mflo      = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    w_signed    = 1'b0;
    if (md_en_i) begin
      case (funct_i)
        FUNCT_MFHI:  w_mfhi = 1'b1;
        FUNCT_MFLO:  w_mflo = 1'b1;
        FUNCT_MTHI:  w_mthi = 1'b1;
        FUNCT_MTLO:  w_mtlo = 1'b1;
        FUNCT_MULT:  begin w_start_mul = 1'b1; w_signed = 1'b1; end
        FUNCT_MULTU: w_start_mul = 1'b1;
        FUNCT_DIV:   begin w_start_div = 1'b1; w_signed = 1'b1; end
        FUNCT_DIVU:  w_start_div = 1'b1;
        default:     ;
      endcase
    end
    w_md_op = w_mfhi | w_mflo | w_mthi | w_mtlo | w_start_mul | w_start_div;
  end

  assign w_rs_neg = w_signed & rs_data_i[DATA_W-1];
  assign w_rt_neg = w_signed & rt_data_i[DATA_W-1];
  assign w_rs_mag = w_rs_neg ? -rs_data_i : rs_data_i;
  assign w_rt_mag = w_rt_neg ? -rt_data_i : rt_data_i;

  assign stall_o   = w_md_op && (r_state != StIdle);
  assign busy_o    = r_busy;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;
  assign mf_data_o = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);

  assign w_mode = (r_state == StDiv) ? MdDiv : MdMul;

  md_step #(
    .DATA_W (DATA_W)
  ) u_md_step (
    .mode_i (w_mode),
    .rem_i  (r_acc_hi),
    .quot_i (r_acc_lo),
    .opnd_i (r_opnd),
    .rem_o  (w_nxt_hi),
    .quot_o (w_nxt_lo)
  );

  // Magnitude results are corrected here; a zero divisor overrides the quotient only.
  assign w_prod = r_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
  assign w_quot = r_div0 ? DIV0_LO[DATA_W-1:0] : (r_neg_res ? -r_acc_lo : r_acc_lo);
  assign w_rem  = r_neg_rem ? -r_acc_hi : r_acc_hi;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_opnd    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start_mul || w_start_div) begin
            r_state   <= w_start_div ? StDiv : StMul;
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_is_div  <= w_start_div;
            r_neg_res <= w_rs_neg ^ w_rt_neg;
            r_neg_rem <= w_start_div & w_rs_neg;
            r_div0    <= w_start_div && (rt_data_i == '0);
            r_acc_hi  <= '0;
            r_acc_lo  <= w_start_div ? w_rs_mag : w_rt_mag;
            r_opnd    <= w_start_div ? w_rt_mag : w_rs_mag;
          end else if (w_mthi) begin
            r_hi <= rs_data_i;
          end else if (w_mtlo) begin
            r_lo <= rs_data_i;
          end
        end
        StMul, StDiv: begin
          r_acc_hi <= w_nxt_hi;
          r_acc_lo <= w_nxt_lo;
          r_count  <= r_count + CNT_W'(1);
          if (r_count == LAST) r_state <= StFix;
        end
        StFix: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl with a HI/LO scoreboard queue.
module tb_mult_div_ctrl;
  import mips_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         md_en;
  logic [5:0]   funct;
  logic [W-1:0] rs, rt;
  logic         stall, busy;
  logic [W-1:0] hi, lo, mf;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] sb_q[$];

  mult_div_ctrl #(.DATA_W(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .md_en_i   (md_en),
    .funct_i   (funct),
    .rs_data_i (rs),
    .rt_data_i (rt),
    .stall_o   (stall),
    .busy_o    (busy),
    .hi_o      (hi),
    .lo_o      (lo),
    .mf_data_o (mf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    md_en = en;
    funct = f;
    rs    = a;
    rt    = b;
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    end
  endtask

  // Issue one op in IDLE, wait out busy, and check latency plus HI/LO.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cyc;
    @(negedge clk);
    drive(1'b1, f, a, b);
    sb_q.push_back({ehi, elo});
    check({tag, "_accept_stall"}, 64'(stall), 64'd0);
    @(negedge clk);
    drive(1'b0, FUNCT_ADD, '0, '0);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    pop_check(tag);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, FUNCT_MFHI, '0, '0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_hi",    64'(hi),    64'd0);
    check("rst_lo",    64'(lo),    64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_mf",    64'(mf),    64'd0);

    run_op("mult_neg",  FUNCT_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",     FUNCT_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_neg",   FUNCT_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      FUNCT_DIVU,  32'd100,       32'd7, 32'd2,         32'd14);
    run_op("div0",      FUNCT_DIV,   32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div0_neg",  FUNCT_DIV,   32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf",   FUNCT_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MTHI/MFHI/MFLO in IDLE; LO still holds the overflow quotient.
    @(negedge clk);
    drive(1'b1, FUNCT_MTHI, 32'hAA, '0);
    check("mthi_stall", 64'(stall), 64'd0);
    @(negedge clk);
    drive(1'b1, FUNCT_MFHI, '0, '0);
    check("mfhi_stall", 64'(stall), 64'd0);
    check("mfhi_data",  64'(mf),    64'hAA);
    drive(1'b1, FUNCT_MFLO, '0, '0);
    check("mflo_data",  64'(mf),    64'h8000_0000);
    drive(1'b1, FUNCT_ADD, '0, '0);
    check("nonmd_mf",   64'(mf),    64'd0);

    // MFLO right after MULT stalls until IDLE; ADD mid-operation does not stall.
    @(negedge clk);
    drive(1'b1, FUNCT_MULT, 32'h1234, 32'h10);
    sb_q.push_back({32'd0, 32'h0001_2340});
    check("mflo_wait_accept", 64'(stall), 64'd0);
    @(negedge clk);
    drive(1'b1, FUNCT_MFLO, '0, '0);
    check("mflo_wait_stall", 64'(stall), 64'd1);
    cyc = 0;
    while (stall && cyc < 40) begin
      cyc++;
      if (cyc == 5) begin
        drive(1'b1, FUNCT_ADD, '0, '0);
        check("add_no_stall", 64'(stall), 64'd0);
        drive(1'b1, FUNCT_MFLO, '0, '0);
      end
      @(negedge clk);
    end
    check("mflo_stall_cycles", 64'(cyc), 64'(W + 1));
    check("mflo_wait_data",    64'(mf),  64'h0001_2340);
    pop_check("mflo_wait");

    // Back-to-back: second op stalls then starts on the first IDLE cycle.
    @(negedge clk);
    drive(1'b1, FUNCT_MULTU, 32'd5, 32'd6);
    sb_q.push_back({32'd0, 32'd30});
    check("b2b_accept", 64'(stall), 64'd0);
    @(negedge clk);
    drive(1'b1, FUNCT_DIVU, 32'd1000, 32'd10);
    sb_q.push_back({32'd0, 32'd100});
    check("b2b_stall", 64'(stall), 64'd1);
    cyc = 0;
    while (stall && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    pop_check("b2b_first");
    @(negedge clk);
    drive(1'b0, FUNCT_ADD, '0, '0);
    check("b2b_second_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    pop_check("b2b_second");

    // MTLO during a busy DIV waits, then overwrites the DIV's LO.
    @(negedge clk);
    drive(1'b1, FUNCT_DIVU, 32'd100, 32'd7);
    sb_q.push_back({32'd2, 32'd14});
    @(negedge clk);
    drive(1'b1, FUNCT_MTLO, 32'h55, '0);
    check("mtlo_stall", 64'(stall), 64'd1);
    cyc = 0;
    while (stall && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    pop_check("mtlo_div");
    @(negedge clk);
    drive(1'b0, FUNCT_ADD, '0, '0);
    check("mtlo_lo",   64'(lo),   64'h55);
    check("mtlo_hi",   64'(hi),   64'd2);
    check("mtlo_busy", 64'(busy), 64'd0);

    // Reset pulsed while count is 10 aborts the MULT and zeroes HI/LO.
    @(negedge clk);
    drive(1'b1, FUNCT_MULT, 32'h1111_1111, 32'd3);
    @(negedge clk);
    drive(1'b0, FUNCT_ADD, '0, '0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, FUNCT_MFHI, '0, '0);
    check("abort_busy",  64'(busy),  64'd0);
    check("abort_hi",    64'(hi),    64'd0);
    check("abort_lo",    64'(lo),    64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    run_op("after_abort", FUNCT_MULT, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
